dff_bank_arbiter: RTL and testbench

Round-robin arbiter and access sequencer that shares one bank of gate-level D flip-flop registers between several requesters. It sits between the requester ports and the register bank's write-enable/address/data pins, serialises single-word read and write transactions, and returns read data with a one-cycle acknowledge. It does not hold data itself; the bank storage is external.

---
 rtl/dff_bank_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and access sequencer sharing one external DFF register bank
// between NREQ requesters. Each transaction runs IDLE -> XFER -> DONE: the winner's
// request is captured in IDLE, the bank is accessed in XFER, and ack/rdata/err are
// presented in DONE.
// Optional feature: define ARB_LOCK_EN to let a locked winner chain transactions
// DONE -> XFER without re-arbitrating. When it is undefined, the lock input is ignored.
module dff_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          ack,
  output logic [WIDTH-1:0]         rdata,
  output logic                     err,
  output logic                     bank_we,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [WIDTH-1:0]         bank_wdata,
  input  logic [WIDTH-1:0]         bank_rdata
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 wr_q, wr_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 bank_we_q, bank_we_d;
  logic [ADDR_W-1:0]    bank_addr_q, bank_addr_d;
  logic [WIDTH-1:0]     bank_wdata_q, bank_wdata_d;

  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx;
  logic [31:0]          cand;
  logic [IDX_W-1:0]     src_idx;
  logic                 src_wr;
  logic [ADDR_W-1:0]    src_addr;
  logic [WIDTH-1:0]     src_wdata;
  logic                 go_idle;

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Only non-power-of-two depths can produce an out-of-range address.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < DEPTH;
  endfunction

  // Round-robin pick: first requesting index at or above ptr, wrapping modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {{(32-IDX_W){1'b0}}, ptr_q} + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!sel_found && req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Request fields of the requester being captured: the new winner in IDLE,
  // the locked winner in DONE.
  always_comb begin
    src_idx   = (state_q == StDone) ? win_q : sel_idx;
    src_wr    = wr[src_idx];
    src_addr  = addr[src_idx*ADDR_W +: ADDR_W];
    src_wdata = wdata[src_idx*WIDTH +: WIDTH];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    wr_d         = wr_q;
    gnt_d        = gnt_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    bank_we_d    = bank_we_q;
    bank_addr_d  = bank_addr_q;
    bank_wdata_d = bank_wdata_q;
    go_idle      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          win_d          = sel_idx;
          wr_d           = src_wr;
          gnt_d          = '0;
          gnt_d[sel_idx] = 1'b1;
          bank_addr_d    = src_addr;
          bank_wdata_d   = src_wdata;
          bank_we_d      = src_wr && in_range(src_addr);
          state_d        = StXfer;
        end else begin
          gnt_d        = '0;
          rdata_d      = '0;
          err_d        = 1'b0;
          bank_we_d    = 1'b0;
          bank_addr_d  = '0;
          bank_wdata_d = '0;
        end
      end
      StXfer: begin
        bank_we_d = 1'b0;
        rdata_d   = (!wr_q && in_range(bank_addr_q)) ? bank_rdata : '0;
        err_d     = !in_range(bank_addr_q);
        ack_d     = gnt_q;
        state_d   = StDone;
      end
      StDone: begin
`ifdef ARB_LOCK_EN
        if (lock[win_q] && req[win_q]) begin
          // Locked winner: re-capture its request, keep gnt and ptr.
          wr_d         = src_wr;
          bank_addr_d  = src_addr;
          bank_wdata_d = src_wdata;
          bank_we_d    = src_wr && in_range(src_addr);
          rdata_d      = '0;
          err_d        = 1'b0;
          state_d      = StXfer;
        end else begin
          go_idle = 1'b1;
        end
`else
        go_idle = 1'b1;
`endif
        if (go_idle) begin
          ptr_d        = (win_q == IDX_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
          gnt_d        = '0;
          rdata_d      = '0;
          err_d        = 1'b0;
          bank_we_d    = 1'b0;
          bank_addr_d  = '0;
          bank_wdata_d = '0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      win_q        <= '0;
      wr_q         <= 1'b0;
      gnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      bank_we_q    <= 1'b0;
      bank_addr_q  <= '0;
      bank_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      wr_q         <= wr_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      bank_we_q    <= bank_we_d;
      bank_addr_q  <= bank_addr_d;
      bank_wdata_q <= bank_wdata_d;
    end
  end

  assign gnt        = gnt_q;
  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign bank_we    = bank_we_q;
  assign bank_addr  = bank_addr_q;
  assign bank_wdata = bank_wdata_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench for dff_bank_arbiter (NREQ=4, WIDTH=8, DEPTH=6) with a
// behavioural register bank. Table-driven single transactions plus hand-written
// reset, fairness and lock sequences.
module tb_dff_bank_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 3;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   wr;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]   lock;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [WIDTH-1:0]  rdata;
  logic              err;
  logic              bank_we;
  logic [AW-1:0]     bank_addr;
  logic [WIDTH-1:0]  bank_wdata;
  logic [WIDTH-1:0]  bank_rdata;

  logic [WIDTH-1:0]  mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  dff_bank_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .lock      (lock),
    .gnt       (gnt),
    .ack       (ack),
    .rdata     (rdata),
    .err       (err),
    .bank_we   (bank_we),
    .bank_addr (bank_addr),
    .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External bank: out-of-range reads return a non-zero pattern the DUT must hide.
  always @(posedge clk) begin
    if (bank_we && bank_addr < AW'(DEPTH)) mem[bank_addr] <= bank_wdata;
  end
  assign bank_rdata = (bank_addr < AW'(DEPTH)) ? mem[bank_addr] : 8'hEE;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " gnt"}, 32'(gnt), 0);
    check({tag, " ack"}, 32'(ack), 0);
    check({tag, " rdata"}, 32'(rdata), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " bank_we"}, 32'(bank_we), 0);
    check({tag, " bank_addr"}, 32'(bank_addr), 0);
    check({tag, " bank_wdata"}, 32'(bank_wdata), 0);
  endtask

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] wr;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [3:0] gnt;
    logic       we;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Each vector is a full transaction from IDLE; ptr carries over between rows.
    vecs[0] = '{4'b0001, 4'b0001, 3'd3, 8'hA5, 4'b0001, 1'b1, 8'h00, 1'b0};
    vecs[1] = '{4'b0001, 4'b0000, 3'd3, 8'h00, 4'b0001, 1'b0, 8'hA5, 1'b0};
    vecs[2] = '{4'b0100, 4'b0100, 3'd5, 8'h3C, 4'b0100, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{4'b0010, 4'b0010, 3'd7, 8'hFF, 4'b0010, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{4'b0011, 4'b0000, 3'd5, 8'h00, 4'b0001, 1'b0, 8'h3C, 1'b0};
    vecs[5] = '{4'b1010, 4'b1000, 3'd0, 8'h11, 4'b0010, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{4'b1010, 4'b1000, 3'd0, 8'h11, 4'b1000, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{4'b1010, 4'b0000, 3'd0, 8'h00, 4'b0010, 1'b0, 8'h11, 1'b0};
    vecs[8] = '{4'b0001, 4'b0000, 3'd6, 8'h00, 4'b0001, 1'b0, 8'h00, 1'b1};

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    rst = 1'b1; req = 4'b1111; wr = '0; addr = '0; wdata = '0; lock = '0;

    // Reset held 2 cycles with all requests high.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("post-reset first gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    tick();

    // Reset during XFER aborts the transaction.
    req = 4'b0100; wr = 4'b0100; addr = {4{3'd2}}; wdata = {4{8'h55}};
    tick();
    check("midop xfer gnt", 32'(gnt), 32'b0100);
    check("midop xfer we", 32'(bank_we), 1);
    rst = 1'b1; req = '0;
    tick();
    check_all_zero("midop reset");
    rst = 1'b0;
    tick();
    check("midop no late ack", 32'(ack), 0);

    // Table-driven transactions.
    for (int v = 0; v < 9; v++) begin
      req = vecs[v].req; wr = vecs[v].wr;
      addr = {4{vecs[v].addr}}; wdata = {4{vecs[v].wdata}};
      tick();
      check($sformatf("v%0d gnt", v), 32'(gnt), 32'(vecs[v].gnt));
      check($sformatf("v%0d bank_we", v), 32'(bank_we), 32'(vecs[v].we));
      check($sformatf("v%0d bank_addr", v), 32'(bank_addr), 32'(vecs[v].addr));
      check($sformatf("v%0d bank_wdata", v), 32'(bank_wdata), 32'(vecs[v].wdata));
      check($sformatf("v%0d early ack", v), 32'(ack), 0);
      // Request is captured: later changes must not leak in.
      req = '0; addr = ~addr; wdata = ~wdata;
      tick();
      check($sformatf("v%0d ack", v), 32'(ack), 32'(vecs[v].gnt));
      check($sformatf("v%0d rdata", v), 32'(rdata), 32'(vecs[v].rdata));
      check($sformatf("v%0d err", v), 32'(err), 32'(vecs[v].err));
      check($sformatf("v%0d we done", v), 32'(bank_we), 0);
      check($sformatf("v%0d gnt held", v), 32'(gnt), 32'(vecs[v].gnt));
      tick();
      check($sformatf("v%0d gnt drop", v), 32'(gnt), 0);
      check($sformatf("v%0d ack drop", v), 32'(ack), 0);
    end

    // Fairness: all requests held, order 0,1,2,3,0 at 3-cycle spacing.
    rst = 1'b1; req = '0;
    tick();
    tick();
    rst = 1'b0;
    req = 4'b1111; wr = '0; addr = '0; wdata = '0;
    for (int t = 0; t < 5; t++) begin
      tick();
      check($sformatf("rr%0d gnt", t), 32'(gnt), 32'(1) << (t % 4));
      tick();
      check($sformatf("rr%0d ack", t), 32'(ack), 32'(1) << (t % 4));
      tick();
      check($sformatf("rr%0d idle", t), 32'(gnt), 0);
    end

    // Lock sequence: requester 2 locked, requester 0 waiting.
    rst = 1'b1; req = '0;
    tick();
    tick();
    rst = 1'b0;
    req = 4'b0100; wr = 4'b0100; lock = 4'b0100; addr = {4{3'd1}}; wdata = {4{8'h77}};
    tick();
    check("lock t0 gnt", 32'(gnt), 32'b0100);
    req = 4'b0101;
    tick();
    check("lock t0 ack", 32'(ack), 32'b0100);
`ifdef ARB_LOCK_EN
    tick();
    check("lock t1 gnt", 32'(gnt), 32'b0100);
    check("lock t1 no ack", 32'(ack), 0);
    check("lock t1 we", 32'(bank_we), 1);
    tick();
    check("lock t1 ack", 32'(ack), 32'b0100);
    tick();
    check("lock t2 gnt", 32'(gnt), 32'b0100);
    lock = '0; req = 4'b0001;
    tick();
    check("lock t2 ack", 32'(ack), 32'b0100);
    tick();
    check("lock release idle", 32'(gnt), 0);
    tick();
    check("lock then gnt0", 32'(gnt), 32'b0001);
`else
    tick();
    check("lock ignored idle", 32'(gnt), 0);
    tick();
    check("lock ignored gnt0", 32'(gnt), 32'b0001);
`endif
    req = '0; lock = '0;
    tick();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
